// File: rtl/frame_scheduler_pkg.sv
// Shared constants and state encoding for the frame scheduler and its FPS divider peer.
// The send_counter width lives here so both ends of the countdown agree.
package frame_scheduler_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 50000000;
  localparam int unsigned SEND_CNT_W     = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rate_meter.sv
// Counts completed frames over 1 s windows; fps_measured updates on the window's last cycle.
// One cycle latency from frame_done to the saturating count; no backpressure.
module rate_meter
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned FPS_W  = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             frame_done,
  output logic [FPS_W-1:0] fps_measured,
  output logic             fps_valid
);

  localparam int unsigned     WIN_W    = $clog2(CLK_HZ);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_HZ - 1);
  localparam logic [FPS_W-1:0] FPS_MAX  = '1;

  logic [WIN_W-1:0] win_q, win_d;
  logic [FPS_W-1:0] cnt_q, cnt_d, fps_q, fps_d, cnt_inc;
  logic             valid_q, valid_d, win_end;

  always_comb begin
    win_end = (win_q == '0);
    cnt_inc = (frame_done && (cnt_q != FPS_MAX)) ? cnt_q + FPS_W'(1) : cnt_q;
    win_d   = win_end ? WIN_LAST : win_q - WIN_W'(1);
    cnt_d   = cnt_inc;
    fps_d   = fps_q;
    valid_d = valid_q;
    // The closing cycle's own completion belongs to the window being reported.
    if (win_end) begin
      fps_d   = cnt_inc;
      cnt_d   = '0;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      win_q   <= WIN_LAST;
      cnt_q   <= '0;
      fps_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      fps_q   <= fps_d;
      valid_q <= valid_d;
    end
  end

  assign fps_measured = fps_q;
  assign fps_valid    = valid_q;

endmodule

// File: rtl/frame_scheduler.sv
// Turns send_counter zero crossings into draw_req/draw_done frames, one pending slot, drop count.
// All outputs registered, one cycle after the sampling edge; ticks arriving with a full slot are dropped.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned CNT_W  = SEND_CNT_W,
  parameter int unsigned FPS_W  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [CNT_W-1:0]  send_counter,
  input  logic              enable,
  input  logic              draw_done,
  output logic              draw_req,
  output logic              frame_tick,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count,
  output logic [FPS_W-1:0]  fps_measured,
  output logic              fps_valid
);

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              tick_q, req_q, busy_q;
  logic              tick, frame_done;

  assign tick = enable && (send_counter == '0);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    drop_d     = drop_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: if (tick) state_d = ST_DRAW;
      ST_DRAW: begin
        if (tick && pending_q && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
        if (draw_done) begin
          frame_done = 1'b1;
          // A tick coinciding with completion becomes the next frame directly.
          if (pending_q || tick) begin
            state_d   = ST_GAP;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          pending_d = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_DRAW;
        if (tick) pending_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      drop_q    <= '0;
      tick_q    <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      tick_q    <= tick;
      req_q     <= (state_d == ST_DRAW);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign draw_req   = req_q;
  assign frame_tick = tick_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;

  rate_meter #(
    .CLK_HZ(CLK_HZ),
    .FPS_W (FPS_W)
  ) u_rate_meter (
    .clock       (clock),
    .resetn      (resetn),
    .frame_done  (frame_done),
    .fps_measured(fps_measured),
    .fps_valid   (fps_valid)
  );

endmodule
